// File: rtl/player_input.sv
// player_input: debounces active-low keys into levels and press pulses, captures moves with valid/ack.
// Optional auto-repeat of press pulses while held: define PLAYER_INPUT_REPEAT_EN.
module player_input #(
  parameter int NUM_KEYS = 4,
  parameter int DB_CYCLES = 500000,
  parameter int CNT_W = 25,
  parameter int REPEAT_CYCLES = 25000000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_KEYS-1:0] key_n,
  input  logic [1:0]          sw_move,
  output logic [NUM_KEYS-1:0] key_level,
  output logic [NUM_KEYS-1:0] key_press,
  output logic                move_valid,
  output logic [1:0]          move_sel,
  input  logic                move_ack,
  output logic                cancel_pulse
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] PEND = 1'b1;
  localparam logic [CNT_W-1:0] DB_MAX = CNT_W'(DB_CYCLES - 1);
  logic [NUM_KEYS-1:0] sync1, sync2, level_nxt, rise;
  logic [1:0] sw1, sw2;
  logic [0:0] state;
  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
    logic s, hit, rep;
    logic [CNT_W-1:0] cnt;
    assign s = ~sync2[i];
    assign hit = s != key_level[i] && cnt == DB_MAX;
    assign level_nxt[i] = hit ? s : key_level[i];
    always_ff @(posedge clk or posedge rst)
      if (rst) cnt <= '0;
      else cnt <= (s == key_level[i] || hit) ? '0 : cnt + 1'b1;
`ifdef PLAYER_INPUT_REPEAT_EN
    localparam logic [CNT_W-1:0] RP_MAX = CNT_W'(REPEAT_CYCLES - 1);
    logic [CNT_W-1:0] rcnt;
    // only counts while the key stays held across the edge, so a release never fires a stray repeat
    assign rep = key_level[i] && level_nxt[i] && rcnt == RP_MAX;
    always_ff @(posedge clk or posedge rst)
      if (rst) rcnt <= '0;
      else rcnt <= (key_level[i] && level_nxt[i] && !rep) ? rcnt + 1'b1 : '0;
`else
    assign rep = 1'b0;
`endif
    assign rise[i] = (level_nxt[i] & ~key_level[i]) | rep;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sync1 <= '1;
      sync2 <= '1;
      sw1 <= 2'b00;
      sw2 <= 2'b00;
      key_level <= '0;
      key_press <= '0;
      state <= IDLE;
      move_valid <= 1'b0;
      move_sel <= 2'b00;
      cancel_pulse <= 1'b0;
    end else begin
      sync1 <= key_n;
      sync2 <= sync1;
      sw1 <= sw_move;
      sw2 <= sw1;
      key_level <= level_nxt;
      key_press <= rise;
      cancel_pulse <= state == PEND && !move_ack && key_press[1];
      if (state == IDLE && key_press[0]) begin
        state <= PEND;
        move_valid <= 1'b1;
        move_sel <= sw2;
      end else if (state == PEND && (move_ack || key_press[1])) begin
        state <= IDLE;
        move_valid <= 1'b0;
      end
    end
endmodule
